i2c_passthru_bitrx: RTL

I2C_PASSTHRU_BITRX -- requirements
Module: i2c_passthru_bitrx

---
 rtl/i2c_passthru_pkg.sv | 24 ++
 rtl/i2c_passthru_bitrx_if.sv | 27 ++
 rtl/i2c_passthru_spike_filt.sv | 53 +++++
 rtl/i2c_passthru_bitrx.sv | 123 ++++++++++++
 4 files changed

// File: rtl/i2c_passthru_pkg.sv
// Shared constants and types for the I2C passthrough bit receiver and transmitter.
package i2c_passthru_pkg;

    localparam int F_REF_T_SPIKE_DEF       = 2;
    localparam int WIDTH_F_REF_T_SPIKE_DEF = 2;

    // Bit-transmitter timing, in i_f_ref periods
    localparam int TX_T_SETUP_REF_DEF = 4;
    localparam int TX_T_HOLD_REF_DEF  = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOW  = 3'd1,
        ST_LOW       = 3'd2,
        ST_HIGH      = 3'd3,
        ST_VIOLATION = 3'd4
    } bitrx_state_e;

    // Only SDA movement while raw SCL is still high counts as a mid-bit change.
    function automatic logic sda_changed(input logic sda, input logic sda_final, input logic scl_raw);
        return (sda != sda_final) && scl_raw;
    endfunction

endpackage

// File: rtl/i2c_passthru_bitrx_if.sv
// Bus-side signals of the bit receiver; slave is the receiver, master the environment.
interface i2c_passthru_bitrx_if;
    logic i_f_ref;
    logic i_start_rx;
    logic i_scl;
    logic i_sda;
    logic o_sda_init_valid;
    logic o_sda_init;
    logic o_sda_mid_change;
    logic o_sda_final;
    logic o_done;
    logic o_start_det;
    logic o_stop_det;
    logic o_violation;

    modport slave (
        input  i_f_ref, i_start_rx, i_scl, i_sda,
        output o_sda_init_valid, o_sda_init, o_sda_mid_change, o_sda_final,
        output o_done, o_start_det, o_stop_det, o_violation
    );

    modport master (
        output i_f_ref, i_start_rx, i_scl, i_sda,
        input  o_sda_init_valid, o_sda_init, o_sda_mid_change, o_sda_final,
        input  o_done, o_start_det, o_stop_det, o_violation
    );
endinterface

// File: rtl/i2c_passthru_spike_filt.sv
// SCL spike filter: a new raw level is accepted only after persisting F_REF_T_SPIKE reference edges.
module i2c_passthru_spike_filt
    import i2c_passthru_pkg::*;
#(
    parameter int F_REF_T_SPIKE       = F_REF_T_SPIKE_DEF,
    parameter int WIDTH_F_REF_T_SPIKE = WIDTH_F_REF_T_SPIKE_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_f_ref,
    input  logic i_scl,
    output logic o_scl_filt
);

    localparam logic [WIDTH_F_REF_T_SPIKE-1:0] CNT_MAX = WIDTH_F_REF_T_SPIKE'(F_REF_T_SPIKE);
    localparam logic [WIDTH_F_REF_T_SPIKE-1:0] CNT_ONE = WIDTH_F_REF_T_SPIKE'(1);

    logic                           f_ref_q_r;
    logic                           pulse_ref_r;
    logic [WIDTH_F_REF_T_SPIKE-1:0] cnt_r;
    logic                           scl_filt_r;

    // One-cycle pulse on each registered rising edge of the reference
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            f_ref_q_r   <= 1'b0;
            pulse_ref_r <= 1'b0;
        end else begin
            f_ref_q_r   <= i_f_ref;
            pulse_ref_r <= i_f_ref & ~f_ref_q_r;
        end
    end

    // Persistence counter and filtered level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r      <= '0;
            scl_filt_r <= 1'b1;
        end else if (i_scl == scl_filt_r) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_MAX) begin
            scl_filt_r <= i_scl;
            cnt_r      <= '0;
        end else if (pulse_ref_r) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_scl_filt = scl_filt_r;

endmodule

// File: rtl/i2c_passthru_bitrx.sv
// Receives one I2C bit: latches SDA at the filtered SCL rise and classifies SDA activity while SCL is high.
module i2c_passthru_bitrx
    import i2c_passthru_pkg::*;
#(
    parameter int F_REF_T_SPIKE       = F_REF_T_SPIKE_DEF,
    parameter int WIDTH_F_REF_T_SPIKE = WIDTH_F_REF_T_SPIKE_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    i2c_passthru_bitrx_if.slave   bus
);

    bitrx_state_e state_r;
    logic         scl_filt_s;
    logic         sda_init_r;
    logic         sda_final_r;
    logic         init_valid_r;
    logic         mid_change_r;
    logic         done_r;
    logic         start_det_r;
    logic         stop_det_r;
    logic         violation_r;

    i2c_passthru_spike_filt #(
        .F_REF_T_SPIKE       (F_REF_T_SPIKE),
        .WIDTH_F_REF_T_SPIKE (WIDTH_F_REF_T_SPIKE)
    ) u_spike_filt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_f_ref    (bus.i_f_ref),
        .i_scl      (bus.i_scl),
        .o_scl_filt (scl_filt_s)
    );

    // Bit-reception state machine with registered bit outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            sda_init_r   <= 1'b1;
            sda_final_r  <= 1'b1;
            init_valid_r <= 1'b0;
            mid_change_r <= 1'b0;
            done_r       <= 1'b1;
            start_det_r  <= 1'b0;
            stop_det_r   <= 1'b0;
            violation_r  <= 1'b0;
        end else begin
            start_det_r <= 1'b0;
            stop_det_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b1;
                    if (bus.i_start_rx) begin
                        init_valid_r <= 1'b0;
                        mid_change_r <= 1'b0;
                        done_r       <= 1'b0;
                        state_r      <= scl_filt_s ? ST_WAIT_LOW : ST_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!scl_filt_s) begin
                        state_r <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    init_valid_r <= 1'b0;
                    mid_change_r <= 1'b0;
                    done_r       <= 1'b0;
                    if (scl_filt_s) begin
                        sda_init_r   <= bus.i_sda;
                        sda_final_r  <= bus.i_sda;
                        init_valid_r <= 1'b1;
                        state_r      <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    // A filtered fall takes priority over a simultaneous SDA change
                    if (!scl_filt_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else if (sda_changed(bus.i_sda, sda_final_r, bus.i_scl)) begin
                        if (mid_change_r) begin
                            violation_r <= 1'b1;
                            done_r      <= 1'b0;
                            state_r     <= ST_VIOLATION;
                        end else begin
                            mid_change_r <= 1'b1;
                            sda_final_r  <= bus.i_sda;
                            start_det_r  <= sda_init_r;
                            stop_det_r   <= ~sda_init_r;
                        end
                    end
                end
                ST_VIOLATION: begin
                    violation_r <= 1'b1;
                    done_r      <= 1'b0;
                end
                default: begin
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // While SCL is low the init output tracks the live SDA line
    always_comb begin
        if (state_r == ST_LOW) begin
            bus.o_sda_init = bus.i_sda;
        end else begin
            bus.o_sda_init = sda_init_r;
        end
    end

    assign bus.o_sda_init_valid = init_valid_r;
    assign bus.o_sda_mid_change = mid_change_r;
    assign bus.o_sda_final      = sda_final_r;
    assign bus.o_done           = done_r;
    assign bus.o_start_det      = start_det_r;
    assign bus.o_stop_det       = stop_det_r;
    assign bus.o_violation      = violation_r;

endmodule
